// File: rtl/hmi_rx_parser.sv
// HMI return-frame parser: touch, numeric and status frames ending in FF FF FF.
// Registered strobes plus held data, and the auto-mode toggle.
module hmi_rx_parser #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0]  AUTO_PAGE   = 8'h00,
    parameter logic [7:0]  AUTO_COMP   = 8'h0D,
    parameter logic        AUTO_INIT   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_ack,
    output logic        touch_valid,
    output logic [7:0]  touch_page,
    output logic [7:0]  touch_comp,
    output logic        touch_press,
    output logic        num_valid,
    output logic [31:0] num_value,
    output logic        status_valid,
    output logic [7:0]  status_code,
    output logic        frame_err,
    output logic        auto_mode
);
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TERM, DROP} state_t;
    typedef enum logic [1:0] {K_TOUCH, K_NUM, K_STAT} kind_t;

    state_t        state, state_n;
    kind_t         kind;
    logic [2:0]    need;
    logic [2:0]    cnt;
    logic [1:0]    ff_cnt;
    logic [31:0]    pl;
    logic [7:0]    stat_pend;
    logic [GW-1:0] gap;
    logic          commit;
    logic          err_n;
    logic          timeout;
    logic          is_ff;
    logic          auto_hit;

    assign is_ff = (rx_data == 8'hFF);
    // Touch payload lands in the top three bytes after three shifts.
    assign auto_hit = (pl[15:8] == AUTO_PAGE) && (pl[23:16] == AUTO_COMP) && pl[24];

    always_comb begin
        state_n = state;
        commit  = 1'b0;
        err_n   = 1'b0;
        timeout = 1'b0;
        if (rx_ack) begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        (rx_data == 8'h65),
                        (rx_data == 8'h71): state_n = PAYLOAD;
                        (rx_data <= 8'h24): state_n = TERM;
                        is_ff:              state_n = IDLE;
                        default: begin
                            err_n   = 1'b1;
                            state_n = DROP;
                        end
                    endcase
                end
                PAYLOAD: begin
                    if (cnt == need - 3'd1)
                        state_n = TERM;
                end
                TERM: begin
                    if (!is_ff) begin
                        err_n   = 1'b1;
                        state_n = DROP;
                    end else if (ff_cnt == 2'd2) begin
                        commit  = 1'b1;
                        state_n = IDLE;
                    end
                end
                DROP: begin
                    if (is_ff && ff_cnt == 2'd2)
                        state_n = IDLE;
                end
            endcase
        end else if (state != IDLE && gap == GAP_MAX) begin
            timeout = 1'b1;
            state_n = IDLE;
            err_n   = (state != DROP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            kind         <= K_STAT;
            need         <= 3'd0;
            cnt          <= 3'd0;
            ff_cnt       <= 2'd0;
            pl           <= 32'd0;
            stat_pend    <= 8'h00;
            gap          <= '0;
            touch_valid  <= 1'b0;
            touch_page   <= 8'h00;
            touch_comp   <= 8'h00;
            touch_press  <= 1'b0;
            num_valid    <= 1'b0;
            num_value    <= 32'd0;
            status_valid <= 1'b0;
            status_code  <= 8'h00;
            frame_err    <= 1'b0;
            auto_mode    <= AUTO_INIT;
        end else begin
            state        <= state_n;
            touch_valid  <= commit && (kind == K_TOUCH);
            num_valid    <= commit && (kind == K_NUM);
            status_valid <= commit && (kind == K_STAT);
            frame_err    <= err_n;

            if (rx_ack || state == IDLE || timeout)
                gap <= '0;
            else if (gap != GAP_MAX)
                gap <= gap + 1'b1;

            if (timeout)
                ff_cnt <= 2'd0;
            else if (rx_ack) begin
                if (state_n != state)
                    ff_cnt <= 2'd0;
                else if (is_ff)
                    ff_cnt <= ff_cnt + 2'd1;
                else
                    ff_cnt <= 2'd0;
            end

            if (rx_ack && state == IDLE) begin
                cnt <= 3'd0;
                if (rx_data == 8'h65) begin
                    kind <= K_TOUCH;
                    need <= 3'd3;
                end else if (rx_data == 8'h71) begin
                    kind <= K_NUM;
                    need <= 3'd4;
                end else if (rx_data <= 8'h24) begin
                    kind      <= K_STAT;
                    need      <= 3'd0;
                    stat_pend <= rx_data;
                end
            end

            if (rx_ack && state == PAYLOAD) begin
                cnt <= cnt + 3'd1;
                pl  <= {rx_data, pl[31:8]};
            end

            if (commit) begin
                unique case (kind)
                    K_TOUCH: begin
                        touch_page  <= pl[15:8];
                        touch_comp  <= pl[23:16];
                        touch_press <= pl[24];
                        if (auto_hit)
                            auto_mode <= ~auto_mode;
                    end
                    K_NUM:   num_value   <= pl;
                    default: status_code <= stat_pend;
                endcase
            end
        end
    end
endmodule
